// File: rtl/stack_unit_if.sv
// stack_unit_if: toggle-handshake bundle between a producer/consumer pair and
// the stack unit.
//   in_rdy/in_op/in_data : request side, driven by the master (upstream)
//   in_ack               : toggled by the stack unit when a request is captured
//   out_rdy/out_data/out_err : result side, driven by the stack unit
//   out_ack              : toggled by the master (downstream) when a result is consumed
interface stack_unit_if #(
  parameter int N = 32
);
  logic         in_rdy;
  logic [1:0]   in_op;
  logic [N-1:0] in_data;
  logic         in_ack;
  logic         out_rdy;
  logic [N-1:0] out_data;
  logic         out_err;
  logic         out_ack;

  modport master (
    output in_rdy, in_op, in_data, out_ack,
    input  in_ack, out_rdy, out_data, out_err
  );

  modport slave (
    input  in_rdy, in_op, in_data, out_ack,
    output in_ack, out_rdy, out_data, out_err
  );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: LIFO stack with PUSH/POP/TOP/CLEAR requests, one result per request.
//   clock  : system clock, all state on posedge
//   reset  : synchronous active-high reset
//   bus    : stack_unit_if.slave, toggle handshakes on both request and result sides
//   count  : current occupancy 0..DEPTH
//   empty  : count == 0
//   full   : count == DEPTH
// Each request passes IDLE (capture) -> EXEC (stack update) -> REPLY (present result).
module stack_unit #(
  parameter int N         = 32,
  parameter int LOG_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  stack_unit_if.slave        bus,
  output logic [LOG_DEPTH:0] count,
  output logic               empty,
  output logic               full
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   SP_DEPTH = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   SP_ONE   = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] ADDR_ONE = LOG_DEPTH'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_REPLY = 2'd2;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_TOP   = 2'b10;

  logic [1:0]         state_reg;
  logic [LOG_DEPTH:0] sp_reg;
  logic [1:0]         op_reg;
  logic [N-1:0]       data_reg;
  logic [N-1:0]       res_reg;
  logic               res_err_reg;
  logic               in_ack_reg;
  logic               out_rdy_reg;
  logic [N-1:0]       out_data_reg;
  logic               out_err_reg;

  logic [N-1:0] mem [DEPTH];

  logic [LOG_DEPTH-1:0] wr_addr;
  logic [LOG_DEPTH-1:0] rd_addr;
  logic                 wr_en;

  assign count = sp_reg;
  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == SP_DEPTH);

  // When sp==DEPTH the low bits alias entry 0, but wr_en is blocked by full.
  assign wr_addr = sp_reg[LOG_DEPTH-1:0];
  assign rd_addr = sp_reg[LOG_DEPTH-1:0] - ADDR_ONE;
  assign wr_en   = (state_reg == ST_EXEC) && (op_reg == OP_PUSH) && !full && !reset;

  assign bus.in_ack   = in_ack_reg;
  assign bus.out_rdy  = out_rdy_reg;
  assign bus.out_data = out_data_reg;
  assign bus.out_err  = out_err_reg;

  // Storage is not reset; sp alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= data_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      sp_reg       <= '0;
      op_reg       <= OP_PUSH;
      data_reg     <= '0;
      res_reg      <= '0;
      res_err_reg  <= 1'b0;
      in_ack_reg   <= 1'b0;
      out_rdy_reg  <= 1'b0;
      out_data_reg <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_rdy != in_ack_reg) begin
            op_reg     <= bus.in_op;
            data_reg   <= bus.in_data;
            in_ack_reg <= ~in_ack_reg;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_reg)
            OP_PUSH: begin
              if (!full) begin
                sp_reg      <= sp_reg + SP_ONE;
                res_reg     <= data_reg;
                res_err_reg <= 1'b0;
              end else begin
                res_reg     <= '0;
                res_err_reg <= 1'b1;
              end
            end
            OP_POP, OP_TOP: begin
              if (!empty) begin
                res_reg     <= mem[rd_addr];
                res_err_reg <= 1'b0;
                if (op_reg == OP_POP) begin
                  sp_reg <= sp_reg - SP_ONE;
                end
              end else begin
                res_reg     <= '0;
                res_err_reg <= 1'b1;
              end
            end
            default: begin // CLEAR
              sp_reg      <= '0;
              res_reg     <= '0;
              res_err_reg <= 1'b0;
            end
          endcase
          state_reg <= ST_REPLY;
        end
        ST_REPLY: begin
          // Output is free once downstream has acknowledged the previous result.
          if (bus.out_ack == out_rdy_reg) begin
            out_data_reg <= res_reg;
            out_err_reg  <= res_err_reg;
            out_rdy_reg  <= ~out_rdy_reg;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: drives stack_unit (N=8, DEPTH=4) through directed and random
// request sequences and compares every result against a queue-based stack model.
module tb_stack_unit;
  localparam int N     = 8;
  localparam int LD    = 2;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stack_unit_if #(.N(N)) bus ();
  logic [LD:0] count;
  logic        empty;
  logic        full;

  stack_unit #(.N(N), .LOG_DEPTH(LD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .count(count),
    .empty(empty),
    .full (full)
  );

  int total = 0;
  int bad   = 0;
  logic [N-1:0] stk[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference stack behaviour.
  task automatic model(input logic [1:0] op, input logic [N-1:0] d,
                       output logic [N-1:0] rd, output logic re);
    rd = '0;
    re = 1'b0;
    case (op)
      2'b00: if (stk.size() < DEPTH) begin stk.push_back(d); rd = d; end
             else re = 1'b1;
      2'b01: if (stk.size() > 0) rd = stk.pop_back();
             else re = 1'b1;
      2'b10: if (stk.size() > 0) rd = stk[stk.size()-1];
             else re = 1'b1;
      default: stk.delete();
    endcase
  endtask

  task automatic send_req(input logic [1:0] op, input logic [N-1:0] d);
    @(negedge clock);
    bus.in_op   = op;
    bus.in_data = d;
    bus.in_rdy  = ~bus.in_rdy;
  endtask

  task automatic wait_in_ack();
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (bus.in_ack == bus.in_rdy) return;
    end
    check_value("in_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_result(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      if (bus.out_rdy != bus.out_ack) begin
        cyc = i;
        return;
      end
    end
    check_value("out_rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    bus.out_ack = bus.out_rdy;
  endtask

  task automatic check_result(input string tag, input logic [1:0] op, input logic [N-1:0] d,
                              output logic [N-1:0] ed);
    logic ee;
    model(op, d, ed, ee);
    check_value({tag, "_data"}, 32'(bus.out_data), 32'(ed));
    check_value({tag, "_err"}, 32'(bus.out_err), 32'(ee));
    check_value({tag, "_count"}, 32'(count), 32'(stk.size()));
    check_value({tag, "_empty"}, 32'(empty), 32'(stk.size() == 0));
    check_value({tag, "_full"}, 32'(full), 32'(stk.size() == DEPTH));
    $display("txn %s op=%0d in=0x%0h out=0x%0h err=%0b count=%0d",
             tag, op, d, bus.out_data, bus.out_err, count);
  endtask

  // Full transaction: request, check 2-cycle latency, check result, optional hold.
  task automatic xact(input string tag, input logic [1:0] op, input logic [N-1:0] d, input int hold);
    int cyc;
    logic [N-1:0] ed;
    send_req(op, d);
    wait_in_ack();
    wait_result(cyc);
    check_value({tag, "_latency"}, 32'(cyc), 32'd2);
    check_result(tag, op, d, ed);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_value({tag, "_hold"}, 32'(bus.out_data), 32'(ed));
    end
    consume();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_in_ack"}, 32'(bus.in_ack), 32'd0);
    check_value({tag, "_out_rdy"}, 32'(bus.out_rdy), 32'd0);
    check_value({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check_value({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
    check_value({tag, "_count"}, 32'(count), 32'd0);
    check_value({tag, "_empty"}, 32'(empty), 32'd1);
    check_value({tag, "_full"}, 32'(full), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] ed0;
    logic [N-1:0] ed;
    logic pend_exp;
    logic rdy_save;
    int r;

    bus.in_rdy  = 1'b0;
    bus.in_op   = 2'b00;
    bus.in_data = '0;
    bus.out_ack = 1'b0;

    // Reset held two cycles.
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Three pushes, then TOP and three POPs.
    xact("push11", 2'b00, 8'h11, 0);
    xact("push22", 2'b00, 8'h22, 0);
    xact("push33", 2'b00, 8'h33, 0);
    xact("top", 2'b10, 8'h00, 0);
    for (int i = 0; i < 3; i++) xact("pop", 2'b01, 8'h00, 0);

    // Fill to full and overflow once, then POP.
    for (int i = 0; i < 5; i++) xact("pushA", 2'b00, 8'hA0 + 8'(i), 0);
    xact("popA", 2'b01, 8'h00, 0);

    // Underflow and CLEAR on a two-entry stack.
    xact("clr0", 2'b11, 8'h00, 0);
    xact("pop_empty", 2'b01, 8'h00, 0);
    xact("push_c1", 2'b00, 8'h5A, 0);
    xact("push_c2", 2'b00, 8'hA5, 0);
    xact("clr2", 2'b11, 8'h00, 0);

    // Backpressure: first result held unconsumed for 10 cycles.
    send_req(2'b00, 8'hB0);
    wait_in_ack();
    wait_result(cyc);
    check_value("bp0_latency", 32'(cyc), 32'd2);
    check_result("bp0", 2'b00, 8'hB0, ed0);
    rdy_save = bus.out_rdy;
    send_req(2'b00, 8'hB1);
    wait_in_ack();
    send_req(2'b00, 8'hB2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      pend_exp = ~bus.in_rdy;
      check_value("bp_in_ack_held", 32'(bus.in_ack), 32'(pend_exp));
      check_value("bp_out_data_stable", 32'(bus.out_data), 32'(ed0));
      check_value("bp_out_rdy_stable", 32'(bus.out_rdy), 32'(rdy_save));
    end
    consume();
    wait_result(cyc);
    check_result("bp1", 2'b00, 8'hB1, ed);
    wait_in_ack();
    consume();
    wait_result(cyc);
    check_result("bp2", 2'b00, 8'hB2, ed);
    consume();
    repeat (5) @(negedge clock);
    check_value("bp_no_dup", 32'(bus.out_rdy), 32'(bus.out_ack));

    // Reset while a result waits in REPLY.
    send_req(2'b00, 8'hC0);
    wait_in_ack();
    wait_result(cyc);
    check_result("rst_c0", 2'b00, 8'hC0, ed);
    send_req(2'b00, 8'hC1);
    wait_in_ack();
    repeat (3) @(negedge clock);
    reset       = 1'b1;
    bus.in_rdy  = 1'b0;
    bus.out_ack = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset_reply");
    reset = 1'b0;
    stk.delete();

    // Random operations with random consumer delay.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      xact("rnd_push", 2'b00, 8'($urandom), $urandom_range(0, 3));
      else if (r < 7) xact("rnd_pop", 2'b01, 8'h00, $urandom_range(0, 3));
      else if (r < 9) xact("rnd_top", 2'b10, 8'h00, $urandom_range(0, 3));
      else            xact("rnd_clr", 2'b11, 8'h00, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end
endmodule
